// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared constants, FSM state type and mask helper for the result buffer
//
// Purpose: common definitions imported by mm_result_buffer and res_row_pack.
// Contents:
//   MM_LANES / MM_BYTE_W / MM_ROW_W - fixed lane count, byte width, row width
//   mm_res_state_e                  - write-back FSM states
//   mm_byte_mask()                  - byte enables for a row of col_len+1 bytes at byte offset off
package mm_pkg;

  localparam int MM_LANES  = 16;
  localparam int MM_BYTE_W = 8;
  localparam int MM_ROW_W  = MM_LANES * MM_BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_COLLECT = 2'd2
  } mm_res_state_e;

  // ((1 << (col_len+1)) - 1) << off, written per bit so no bit is ever shifted out.
  function automatic logic [MM_LANES-1:0] mm_byte_mask(input logic [3:0] col_len,
                                                       input logic [3:0] off);
    logic [MM_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MM_LANES; i++) begin
      m[i] = (i >= int'(off)) && (i <= int'(off) + int'(col_len));
    end
    return m;
  endfunction

endpackage

// File: rtl/res_row_pack.sv
// rtl/res_row_pack.sv - combinational shift, mask and optional ReLU for one written row
//
// Purpose: turns a collected row (byte c at [c*8+7:c*8]) into the RAM line image.
// Config macro: MM_RES_BUFF_RELU_EN - bytes with bit 7 set are zeroed before the shift.
// Ports:
//   row_i     in  128  collected row, unfilled bytes already zero
//   off_i     in  4    byte offset within the line
//   col_len_i in  4    columns-1
//   data_o    out 128  row shifted left by off_i bytes
//   mask_o    out 16   byte enables covering off_i .. off_i+col_len_i
module res_row_pack
  import mm_pkg::*;
(
  input  logic [MM_ROW_W-1:0] row_i,
  input  logic [3:0]          off_i,
  input  logic [3:0]          col_len_i,
  output logic [MM_ROW_W-1:0] data_o,
  output logic [MM_LANES-1:0] mask_o
);

  logic [MM_ROW_W-1:0] row_act;

  always_comb begin
    row_act = row_i;
`ifdef MM_RES_BUFF_RELU_EN
    for (int c = 0; c < MM_LANES; c++) begin
      if (row_i[c*MM_BYTE_W + MM_BYTE_W - 1]) begin
        row_act[c*MM_BYTE_W +: MM_BYTE_W] = '0;
      end
    end
`endif
  end

  // Offset is a byte count; {off,3'b000} is the bit shift.
  assign data_o = row_act << {off_i, 3'b000};
  assign mask_o = mm_byte_mask(col_len_i, off_i);

endmodule

// File: rtl/mm_result_buffer.sv
// rtl/mm_result_buffer.sv - de-skews diagonal MXU result bytes into byte-masked RAM row writes
//
// Purpose: lane c delivers row r at drain cycle t=r+c; bytes are collected into 16 row
// entries and row r is written (registered) at t=r+col_len+1.
// Config macro: MM_RES_BUFF_RELU_EN (applied inside res_row_pack).
// Ports:
//   clk, rst                        clock, async active-high reset
//   lsu_mm_res_ctrl_vld             op level; rising edge starts an op
//   lsu_mm_res_ctrl_row_len/col_len rows-1 / cols-1
//   lsu_mm_res_ctrl_start_addr      [11:4] base line, [3:0] byte offset
//   mxu_mm_res_vld/data             per-lane valid and bytes
//   lsu_mm_res_ram_wr_*             registered write strobe, line address, data, byte mask
//   lsu_mm_res_busy/done/err        not idle / last-write pulse / sticky error
module mm_result_buffer
  import mm_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                lsu_mm_res_ctrl_vld,
  input  logic [3:0]          lsu_mm_res_ctrl_row_len,
  input  logic [3:0]          lsu_mm_res_ctrl_col_len,
  input  logic [11:0]         lsu_mm_res_ctrl_start_addr,
  input  logic [MM_LANES-1:0] mxu_mm_res_vld,
  input  logic [MM_ROW_W-1:0] mxu_mm_res_data,
  output logic                lsu_mm_res_ram_wr_vld,
  output logic [7:0]          lsu_mm_res_ram_wr_addr,
  output logic [MM_ROW_W-1:0] lsu_mm_res_ram_wr_data,
  output logic [MM_LANES-1:0] lsu_mm_res_ram_wr_mask,
  output logic                lsu_mm_res_busy,
  output logic                lsu_mm_res_done,
  output logic                lsu_mm_res_err
);

  mm_res_state_e state_q, state_d;
  logic                               ctrl_vld_ff_q;
  logic [3:0]                         row_len_q, row_len_d, col_len_q, col_len_d, off_q, off_d;
  logic [7:0]                         base_q, base_d;
  logic [5:0]                         t_q, t_d;
  logic [MM_LANES-1:0][MM_ROW_W-1:0]  entry_q, entry_d;
  logic [MM_LANES-1:0][MM_LANES-1:0]  fill_q, fill_d;
  logic                               err_q, err_d;
  logic                               wr_vld_q, wr_vld_d, done_q, done_d;
  logic [7:0]                         wr_addr_q, wr_addr_d;
  logic [MM_ROW_W-1:0]                wr_data_q, wr_data_d;
  logic [MM_LANES-1:0]                wr_mask_q, wr_mask_d;

  logic                start, off_bad, active, skew_err, fill_miss, issue;
  logic [5:0]          t_cur, t_last, wr_row6;
  logic [3:0]          wr_row;
  logic [MM_LANES-1:0] in_win, acc;
  logic [3:0]          acc_row [MM_LANES];
  logic [MM_ROW_W-1:0] row_merged, pk_data;
  logic [MM_LANES-1:0] pk_mask;

  assign start   = lsu_mm_res_ctrl_vld & ~ctrl_vld_ff_q;
  assign off_bad = ({1'b0, lsu_mm_res_ctrl_start_addr[3:0]} + {1'b0, lsu_mm_res_ctrl_col_len}) > 5'd15;
  // The WAIT cycle that sees lane 0 valid is t=0 and already captures/issues.
  assign active  = lsu_mm_res_ctrl_vld &&
                   ((state_q == ST_COLLECT) || (state_q == ST_WAIT && mxu_mm_res_vld[0]));
  assign t_cur   = (state_q == ST_COLLECT) ? t_q : 6'd0;
  assign t_last  = {2'b00, row_len_q} + {2'b00, col_len_q} + 6'd1;

  // Capture window per lane: c <= col_len and c <= t <= c+row_len; target entry is t-c.
  always_comb begin
    acc      = '0;
    in_win   = '0;
    skew_err = 1'b0;
    for (int c = 0; c < MM_LANES; c++) begin
      acc_row[c] = 4'(t_cur - 6'(c));
      in_win[c]  = (4'(c) <= col_len_q) && (t_cur >= 6'(c)) &&
                   ((t_cur - 6'(c)) <= {2'b00, row_len_q});
      acc[c]     = active && mxu_mm_res_vld[c] && in_win[c];
      if (active && mxu_mm_res_vld[c] && !in_win[c]) skew_err = 1'b1;
    end
  end

  // Row t-col_len completes this cycle; merge in any same-cycle capture (bypass).
  always_comb begin
    wr_row6    = t_cur - {2'b00, col_len_q};
    wr_row     = wr_row6[3:0];
    issue      = active && (t_cur >= {2'b00, col_len_q}) && (wr_row6 <= {2'b00, row_len_q});
    row_merged = '0;
    fill_miss  = 1'b0;
    for (int c = 0; c < MM_LANES; c++) begin
      if (acc[c] && acc_row[c] == wr_row) begin
        row_merged[c*MM_BYTE_W +: MM_BYTE_W] = mxu_mm_res_data[c*MM_BYTE_W +: MM_BYTE_W];
      end else if (fill_q[wr_row][c]) begin
        row_merged[c*MM_BYTE_W +: MM_BYTE_W] = entry_q[wr_row][c*MM_BYTE_W +: MM_BYTE_W];
      end else if (4'(c) <= col_len_q) begin
        fill_miss = fill_miss | issue;
      end
    end
  end

  res_row_pack u_pack (
    .row_i     (row_merged),
    .off_i     (off_q),
    .col_len_i (col_len_q),
    .data_o    (pk_data),
    .mask_o    (pk_mask)
  );

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    row_len_d = row_len_q;
    col_len_d = col_len_q;
    off_d     = off_q;
    base_d    = base_q;
    entry_d   = entry_q;
    fill_d    = fill_q;
    err_d     = err_q;
    wr_vld_d  = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    wr_mask_d = '0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_len_d = lsu_mm_res_ctrl_row_len;
          col_len_d = lsu_mm_res_ctrl_col_len;
          off_d     = lsu_mm_res_ctrl_start_addr[3:0];
          base_d    = lsu_mm_res_ctrl_start_addr[11:4];
          err_d     = off_bad;
          fill_d    = '0;   // drop leftovers of an aborted op
          if (!off_bad) begin
            state_d = ST_WAIT;
            t_d     = 6'd0;
          end
        end
      end
      ST_WAIT: begin
        if (!lsu_mm_res_ctrl_vld)   state_d = ST_IDLE;
        else if (mxu_mm_res_vld[0]) begin
          state_d = ST_COLLECT;
          t_d     = 6'd1;
        end
      end
      ST_COLLECT: begin
        if (!lsu_mm_res_ctrl_vld) state_d = ST_IDLE;
        else if (t_q >= t_last)   state_d = ST_IDLE;  // last write is on the outputs now
        else                      t_d = t_q + 6'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (skew_err || fill_miss) err_d = 1'b1;

    for (int c = 0; c < MM_LANES; c++) begin
      if (acc[c]) begin
        entry_d[acc_row[c]][c*MM_BYTE_W +: MM_BYTE_W] = mxu_mm_res_data[c*MM_BYTE_W +: MM_BYTE_W];
        fill_d[acc_row[c]][c] = 1'b1;
      end
    end

    if (issue) begin
      fill_d[wr_row] = '0;
      wr_vld_d       = 1'b1;
      wr_addr_d      = base_q + {4'b0000, wr_row};
      wr_data_d      = pk_data;
      wr_mask_d      = pk_mask;
      done_d         = (wr_row == row_len_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ctrl_vld_ff_q <= 1'b0;
      row_len_q     <= '0;
      col_len_q     <= '0;
      off_q         <= '0;
      base_q        <= '0;
      t_q           <= '0;
      entry_q       <= '0;
      fill_q        <= '0;
      err_q         <= 1'b0;
      wr_vld_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_mask_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctrl_vld_ff_q <= lsu_mm_res_ctrl_vld;
      row_len_q     <= row_len_d;
      col_len_q     <= col_len_d;
      off_q         <= off_d;
      base_q        <= base_d;
      t_q           <= t_d;
      entry_q       <= entry_d;
      fill_q        <= fill_d;
      err_q         <= err_d;
      wr_vld_q      <= wr_vld_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_mask_q     <= wr_mask_d;
      done_q        <= done_d;
    end
  end

  assign lsu_mm_res_ram_wr_vld  = wr_vld_q;
  assign lsu_mm_res_ram_wr_addr = wr_addr_q;
  assign lsu_mm_res_ram_wr_data = wr_data_q;
  assign lsu_mm_res_ram_wr_mask = wr_mask_q;
  assign lsu_mm_res_busy        = (state_q != ST_IDLE);
  assign lsu_mm_res_done        = done_q;
  assign lsu_mm_res_err         = err_q;

endmodule
